// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//   Seven-segment scan controller for the pingpong score display. Eight
//   common-anode digits are time-multiplexed to show "AA  --  BB". Each
//   transition of the divider's scan level advances the digit index by one.
//   Scores are latched once per frame and saturated to 99. The tens digit is
//   blanked when it is zero. After game over, the winner's pair of digits
//   blinks.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high
//   scan_lvl_i   toggling scan level; either edge is one scan step
//   score_a_i    player A score, binary 0..127
//   score_b_i    player B score, binary 0..127
//   game_over_i  level; enables blinking of the winner's digits
//   winner_i     0 = A won, 1 = B won (valid while game_over_i = 1)
//   an_o         digit enables, active-low, an_o[7] = leftmost digit
//   seg_o        segments, active-low, {dp,g,f,e,d,c,b,a}; dp always off
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
   parameter int BLINK_SCANS = 250
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scan_lvl_i,
   input  logic [6:0] score_a_i,
   input  logic [6:0] score_b_i,
   input  logic       game_over_i,
   input  logic       winner_i,
   output logic [7:0] an_o,
   output logic [7:0] seg_o
);

   localparam int CW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
   localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_SCANS - 1);

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;

   // What each scan position shows.
   typedef enum logic [1:0] {
      D_NUM_ZB, // numeric, blank when zero (tens digit)
      D_NUM,    // numeric, always shown (units digit)
      D_DASH,
      D_BLANK
   } dig_kind_e;

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------
   function automatic logic [6:0] sat99(input logic [6:0] v);
      return (v > 7'd99) ? 7'd99 : v;
   endfunction

   function automatic logic [3:0] tens_of(input logic [6:0] v);
      return 4'(v / 7'd10);
   endfunction

   function automatic logic [3:0] units_of(input logic [6:0] v);
      return 4'(v % 7'd10);
   endfunction

   function automatic logic [7:0] glyph(input logic [3:0] d);
      logic [7:0] g;
      case (d)
         4'd0:    g = 8'hC0;
         4'd1:    g = 8'hF9;
         4'd2:    g = 8'hA4;
         4'd3:    g = 8'hB0;
         4'd4:    g = 8'h99;
         4'd5:    g = 8'h92;
         4'd6:    g = 8'h82;
         4'd7:    g = 8'hF8;
         4'd8:    g = 8'h80;
         4'd9:    g = 8'h90;
         default: g = SEG_BLANK;
      endcase
      return g;
   endfunction

   // ------------------------------------------------------------------
   // Scan-step detection: two sync flops plus a history flop; any change
   // between the last two synchronized samples is one step.
   // ------------------------------------------------------------------
   logic s1_q, s2_q, s3_q;
   logic step;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= scan_lvl_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign step = s2_q ^ s3_q;

   // ------------------------------------------------------------------
   // Digit index and per-frame score latch
   // ------------------------------------------------------------------
   logic [2:0] idx_q, idx_d;
   logic [6:0] lat_a_q, lat_a_d;
   logic [6:0] lat_b_q, lat_b_d;
   logic       wrap;

   // The step that moves idx from 0 back to 7 starts a new frame.
   assign wrap = step && (idx_q == 3'd0);

   always_comb begin
      idx_d   = idx_q;
      lat_a_d = lat_a_q;
      lat_b_d = lat_b_q;
      if (step) begin
         idx_d = idx_q - 3'd1; // 3-bit wrap 0 -> 7
      end
      if (wrap) begin
         lat_a_d = sat99(score_a_i);
         lat_b_d = sat99(score_b_i);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q   <= 3'd7;
         lat_a_q <= 7'd0;
         lat_b_q <= 7'd0;
      end else begin
         idx_q   <= idx_d;
         lat_a_q <= lat_a_d;
         lat_b_q <= lat_b_d;
      end
   end

   // ------------------------------------------------------------------
   // Blink timer. Held cleared while the game is running. A step landing
   // in the same cycle as the game_over rise is already counted.
   // ------------------------------------------------------------------
   logic [CW-1:0] blink_cnt_q, blink_cnt_d;
   logic          phase_q, phase_d;

   always_comb begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if (!game_over_i) begin
         blink_cnt_d = '0;
         phase_d     = 1'b0;
      end else if (step) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
      end
   end

   // ------------------------------------------------------------------
   // Digit content for the current index
   // ------------------------------------------------------------------
   dig_kind_e  kind;
   logic [3:0] digit;
   logic       win_digit;
   logic [7:0] seg_d, an_d;

   always_comb begin
      kind      = D_BLANK;
      digit     = 4'd0;
      win_digit = 1'b0;
      case (idx_q)
         3'd7: begin kind = D_NUM_ZB; digit = tens_of(lat_a_q);  win_digit = !winner_i; end
         3'd6: begin kind = D_NUM;    digit = units_of(lat_a_q); win_digit = !winner_i; end
         3'd4,
         3'd3: kind = D_DASH;
         3'd1: begin kind = D_NUM_ZB; digit = tens_of(lat_b_q);  win_digit = winner_i;  end
         3'd0: begin kind = D_NUM;    digit = units_of(lat_b_q); win_digit = winner_i;  end
         default: kind = D_BLANK;
      endcase
   end

   always_comb begin
      seg_d = SEG_BLANK;
      case (kind)
         D_NUM_ZB: seg_d = (digit == 4'd0) ? SEG_BLANK : glyph(digit);
         D_NUM:    seg_d = glyph(digit);
         D_DASH:   seg_d = SEG_DASH;
         default:  seg_d = SEG_BLANK;
      endcase
      // Hidden half of the blink only blanks the winner's segments; the
      // anode keeps scanning so the refresh cadence is unchanged.
      if (phase_q && win_digit) begin
         seg_d = SEG_BLANK;
      end
   end

   assign an_d = ~(8'd1 << idx_q);

   // ------------------------------------------------------------------
   // Output register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an_o  <= 8'hFF;
         seg_o <= 8'hFF;
      end else begin
         an_o  <= an_d;
         seg_o <= seg_d;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

   localparam int B = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       scan_lvl;
   logic [6:0] score_a, score_b;
   logic       game_over, winner;
   logic [7:0] an, seg;

   seg_scan_ctrl #(.BLINK_SCANS(B)) dut (
      .clk        (clk),
      .reset      (reset),
      .scan_lvl_i (scan_lvl),
      .score_a_i  (score_a),
      .score_b_i  (score_b),
      .game_over_i(game_over),
      .winner_i   (winner),
      .an_o       (an),
      .seg_o      (seg)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: steps since reset, latched scores, blink step count
   int n, mla, mlb, gcnt;
   logic [7:0] GLY [10];
   logic [7:0] exp2 [8];

   function automatic int sat(input int v);
      return (v > 99) ? 99 : v;
   endfunction

   function automatic int m_idx();
      return 7 - (n % 8);
   endfunction

   function automatic logic [7:0] m_an();
      logic [7:0] a;
      a = 8'hFF;
      a[m_idx()] = 1'b0;
      return a;
   endfunction

   function automatic logic [7:0] num(input int v, input bit zb);
      if (zb && v == 0) return 8'hFF;
      return GLY[v];
   endfunction

   function automatic logic [7:0] m_seg();
      int  i;
      bit  hidden;
      i = m_idx();
      hidden = game_over && (((gcnt / B) % 2) == 1) &&
               ((!winner && i >= 6) || (winner && i <= 1));
      if (hidden) return 8'hFF;
      case (i)
         7: return num(mla / 10, 1'b1);
         6: return num(mla % 10, 1'b0);
         4, 3: return 8'hBF;
         1: return num(mlb / 10, 1'b1);
         0: return num(mlb % 10, 1'b0);
         default: return 8'hFF;
      endcase
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h (step %0d)", tag, obs, exp, n);
      end
   endtask

   task automatic model_reset();
      n = 0; mla = 0; mlb = 0; gcnt = 0;
   endtask

   task automatic set_go(input logic v);
      game_over = v;
      if (!v) gcnt = 0;
   endtask

   // Called #1 after a posedge: toggle scan level, update the model, then
   // check that an holds for 3 edges and both outputs land on the 4th.
   task automatic do_step();
      logic [7:0] old_an;
      old_an = m_an();
      scan_lvl = ~scan_lvl;
      n++;
      if (n % 8 == 0) begin
         mla = sat(int'(score_a));
         mlb = sat(int'(score_b));
      end
      if (game_over) gcnt++; else gcnt = 0;
      repeat (3) @(posedge clk);
      #1;
      check("an_hold", an, old_an);
      @(posedge clk);
      #1;
      check("an", an, m_an());
      check("seg", seg, m_seg());
   endtask

   initial begin
      GLY  = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
      exp2 = '{8'hFF, 8'hF8, 8'hFF, 8'hBF, 8'hBF, 8'hFF, 8'hF9, 8'hA4};
      reset = 1'b1; scan_lvl = 1'b0; score_a = '0; score_b = '0;
      game_over = 1'b0; winner = 1'b0;
      model_reset();

      // 1: reset state with scan_lvl toggling, then release
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         scan_lvl = ~scan_lvl;
      end
      check("rst_an", an, 8'hFF);
      check("rst_seg", seg, 8'hFF);
      scan_lvl = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("rel_an", an, 8'h7F);
      check("rel_seg", seg, 8'hFF);
      repeat (5) @(posedge clk);
      #1;
      check("rel_an_hold", an, 8'h7F);

      // 2: A=7, B=12; second frame against fixed glyph sequence
      score_a = 7'd7; score_b = 7'd12;
      repeat (7) do_step();
      for (int k = 0; k < 8; k++) begin
         do_step();
         check("t2_seg", seg, exp2[k]);
         check("t2_an", an, ~(8'h80 >> k));
      end

      // 3: saturation of A, zero B
      score_a = 7'd120; score_b = 7'd0;
      do_step();                       // wrap, idx 7
      check("t3_a_tens", seg, 8'h90);
      do_step();
      check("t3_a_units", seg, 8'h90);
      repeat (5) do_step();            // idx 1
      check("t3_b_tens", seg, 8'hFF);
      do_step();
      check("t3_b_units", seg, 8'hC0);

      // 4: score change mid-frame is invisible until the next wrap
      score_a = 7'd5;
      do_step();                       // wrap latches 5
      do_step();                       // idx 6
      check("t4_old", seg, 8'h92);
      score_a = 7'd6;
      repeat (6) do_step();            // rest of frame, still 5
      do_step();                       // wrap latches 6
      do_step();                       // idx 6
      check("t4_new", seg, 8'h82);

      // 5: blink of B's digits, then game_over drop
      score_b = 7'd3; winner = 1'b1;
      set_go(1'b1);
      repeat (24) do_step();
      set_go(1'b0);
      repeat (8) do_step();

      // 6: reset pulse mid-blink at idx 3
      score_a = 7'd42; score_b = 7'd17; winner = 1'b0;
      set_go(1'b1);
      for (int k = 0; k < 40 && !(m_idx() == 3 && gcnt >= B); k++) do_step();
      reset = 1'b1;
      scan_lvl = 1'b0;
      #1;
      check("t6_rst_an", an, 8'hFF);
      check("t6_rst_seg", seg, 8'hFF);
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      @(posedge clk); #1;
      check("t6_rel_an", an, 8'h7F);
      check("t6_rel_seg", seg, 8'hFF);
      repeat (12) do_step();
      set_go(1'b0);

      // Random scores, game_over and winner
      for (int k = 0; k < 120; k++) begin
         if ($urandom_range(0, 3) == 0) score_a = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 3) == 0) score_b = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 9) == 0) set_go(!game_over);
         if ($urandom_range(0, 15) == 0) winner = !winner;
         do_step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
